fifo_rd_ctrl: RTL and testbench

Read-side controller for the asynchronous FIFO. It sits in the read clock domain downstream of the write-pointer synchronizer. It owns the read pointer, generates empty, occupancy and almost-empty status, and sequences synchronous reads from the dual-port memory into a 2-entry output buffer. Consumers see a valid/ready stream that sustains one word per rclk.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_out_buf.sv | 54 +++++
 rtl/fifo_rd_ctrl.sv | 88 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary pointer conversion.
// Both read-side and write-side controllers import this package.
package fifo_pkg;

  localparam int FIFO_ASIZE = 4;
  localparam int FIFO_DSIZE = 8;

  // Conversions run at a fixed wide width; callers zero-extend in and truncate out,
  // which is exact for any pointer width up to GRAY_W.
  localparam int GRAY_W = 16;

  localparam int OUT_BUF_DEPTH = 2;
  typedef logic [1:0] buf_cnt_t;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry in-order output buffer: write to valid in one clock, head held stable under backpressure.
// A capture and a pop in the same cycle leave the count unchanged.
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wr_data,
  output logic             valid,
  input  logic             ready,
  output logic [DSIZE-1:0] data,
  output buf_cnt_t         cnt
);

  logic [DSIZE-1:0] tail;
  logic             pop;

  assign valid = (cnt != 2'd0);
  assign pop   = valid && ready;

  // data is the head entry; tail is only meaningful when cnt == 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({wr_en, pop})
        2'b10: begin
          if (cnt == 2'd0) data <= wr_data;
          else             tail <= wr_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          data <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            data <= wr_data;
          end else begin
            data <= tail;
            tail <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: read pointer, empty/count status, memory read sequencing into a 2-entry buffer.
// First word valid 3 rclk after wptr_sync moves; one word per rclk sustained; reads stall when buffer + in-flight would exceed 2.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ASIZE    = FIFO_ASIZE,
  parameter int DSIZE    = FIFO_DSIZE,
  parameter int AE_LEVEL = 2
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [ASIZE:0]   wptr_sync,
  output logic [ASIZE:0]   rptr,
  output logic             mem_ren,
  output logic [ASIZE-1:0] raddr,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic             dout_valid,
  output logic [DSIZE-1:0] dout,
  input  logic             dout_ready,
  output logic             rempty,
  output logic [ASIZE:0]   rcount,
  output logic             ralmost_empty
);

  localparam int PW = ASIZE + 1;
  localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

  if (PW > GRAY_W) begin : g_width_check
    $error("fifo_rd_ctrl: pointer width exceeds fifo_pkg::GRAY_W");
  end

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rcount_next;
  logic          inflight;
  logic          pop;
  buf_cnt_t      buf_cnt;
  logic [2:0]    occ_next;

  assign pop = dout_valid && dout_ready;

  // Occupancy the buffer would have after this cycle's capture and pop;
  // a read issued now lands one cycle later, so it must find a free slot.
  assign occ_next = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign mem_ren  = !rempty && (occ_next < 3'(OUT_BUF_DEPTH));

  assign raddr      = rbin[ASIZE-1:0];
  assign rbin_next  = rbin + {{ASIZE{1'b0}}, mem_ren};
  assign rgray_next = PW'(bin2gray(GRAY_W'(rbin_next)));
  assign wbin       = PW'(gray2bin(GRAY_W'(wptr_sync)));

  // Modulo arithmetic on the extra MSB makes a full FIFO read as 2^ASIZE.
  assign rcount_next = wbin - rbin_next;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      rcount        <= '0;
      ralmost_empty <= 1'b1;
      inflight      <= 1'b0;
    end else begin
      rbin          <= rbin_next;
      rptr          <= rgray_next;
      rempty        <= (rgray_next == wptr_sync);
      rcount        <= rcount_next;
      ralmost_empty <= (rcount_next <= AE_THR);
      inflight      <= mem_ren;
    end
  end

  fifo_out_buf #(
    .DSIZE (DSIZE)
  ) u_out_buf (
    .clk     (rclk),
    .rst     (rrst),
    .wr_en   (inflight),
    .wr_data (mem_rdata),
    .valid   (dout_valid),
    .ready   (dout_ready),
    .data    (dout),
    .cnt     (buf_cnt)
  );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural memory and an in-order data scoreboard.
module tb_fifo_rd_ctrl;

  logic       rclk = 1'b0;
  logic       rrst = 1'b1;
  logic [4:0] wptr_sync = 5'd0;
  logic [4:0] rptr;
  logic       mem_ren;
  logic [3:0] raddr;
  logic [7:0] mem_rdata = 8'd0;
  logic       dout_valid;
  logic [7:0] dout;
  logic       dout_ready = 1'b0;
  logic       rempty;
  logic [4:0] rcount;
  logic       ralmost_empty;

  logic [7:0] mem [16];
  logic [7:0] exp_q [$];
  logic [3:0] exp_raddr = 4'd0;
  int         wbin = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 rclk = ~rclk;

  fifo_rd_ctrl #(.ASIZE(4), .DSIZE(8), .AE_LEVEL(2)) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .wptr_sync     (wptr_sync),
    .rptr          (rptr),
    .mem_ren       (mem_ren),
    .raddr         (raddr),
    .mem_rdata     (mem_rdata),
    .dout_valid    (dout_valid),
    .dout          (dout),
    .dout_ready    (dout_ready),
    .rempty        (rempty),
    .rcount        (rcount),
    .ralmost_empty (ralmost_empty)
  );

  // Synchronous-read memory: data appears one rclk after mem_ren.
  always @(posedge rclk) begin
    if (mem_ren) mem_rdata <= mem[raddr];
  end

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("comparison %s failed", tag);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[4'(wbin)] = d;
    exp_q.push_back(d);
    wbin = (wbin + 1) % 32;
  endtask

  task automatic publish();
    wptr_sync = gray5(wbin);
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    wptr_sync = 5'd0;
    wbin = 0;
    exp_q.delete();
    step();
    step();
    rrst = 1'b0;
    step();
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) step();
    step();
    step();
    chk(tag, exp_q.size(), 0);
  endtask

  // Scoreboard and read-address monitor, sampled mid-cycle.
  always @(negedge rclk) begin
    if (rrst) begin
      exp_raddr = 4'd0;
    end else begin
      if (mem_ren) begin
        chk("raddr", raddr, exp_raddr);
        exp_raddr = exp_raddr + 4'd1;
      end
      if (dout_valid) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          if (dout_ready) chk("dout", dout, exp_q.pop_front());
          else            chk("dout_hold", dout, exp_q[0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(negedge rclk);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_rempty", rempty, 1);
    chk("rst_rptr", rptr, 0);
    chk("rst_rcount", rcount, 0);
    chk("rst_ralmost_empty", ralmost_empty, 1);
    chk("rst_mem_ren", mem_ren, 0);
    step();
    rrst = 1'b0;
    dout_ready = 1'b1;
    step();

    // Single word
    push(8'hA5);
    publish();
    @(negedge rclk);
    chk("sw_rempty_before", rempty, 1);
    chk("sw_ren_before", mem_ren, 0);
    step();
    @(negedge rclk);
    chk("sw_rempty_fall", rempty, 0);
    chk("sw_ren", mem_ren, 1);
    chk("sw_rcount1", rcount, 1);
    step();
    @(negedge rclk);
    chk("sw_rptr", rptr, 5'b00001);
    chk("sw_ren_off", mem_ren, 0);
    chk("sw_rempty_back", rempty, 1);
    chk("sw_rcount0", rcount, 0);
    chk("sw_valid_early", dout_valid, 0);
    step();
    @(negedge rclk);
    chk("sw_valid", dout_valid, 1);
    step();
    @(negedge rclk);
    chk("sw_valid_one_cycle", dout_valid, 0);

    // Burst of 8 from a fresh pointer
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
    publish();
    chk("burst_wptr", wptr_sync, 5'b01100);
    step();
    for (int k = 0; k <= 10; k++) begin
      @(negedge rclk);
      chk($sformatf("burst_rcount_%0d", k), rcount, (k <= 8) ? 8 - k : 0);
      chk($sformatf("burst_ae_%0d", k), ralmost_empty, (k >= 6) ? 1 : 0);
      chk($sformatf("burst_ren_%0d", k), mem_ren, (k < 8) ? 1 : 0);
      chk($sformatf("burst_valid_%0d", k), dout_valid, (k >= 2 && k <= 9) ? 1 : 0);
      step();
    end
    chk("burst_drained", exp_q.size(), 0);

    // Backpressure with 5 words available
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    publish();
    step();
    for (int k = 0; k <= 6; k++) begin
      @(negedge rclk);
      chk($sformatf("bp_ren_%0d", k), mem_ren, (k < 2) ? 1 : 0);
      step();
    end
    @(negedge rclk);
    chk("bp_rcount", rcount, 3);
    chk("bp_valid", dout_valid, 1);
    chk("bp_dout_word0", dout, 8'h50);
    step();
    dout_ready = 1'b1;
    for (int j = 0; j <= 5; j++) begin
      @(negedge rclk);
      chk($sformatf("bp_resume_valid_%0d", j), dout_valid, (j <= 4) ? 1 : 0);
      chk($sformatf("bp_resume_ren_%0d", j), mem_ren, (j <= 2) ? 1 : 0);
      step();
    end
    chk("bp_drained", exp_q.size(), 0);

    // Wrap-around and full
    do_reset();
    for (int i = 0; i < 15; i++) push(8'(8'h10 + i));
    publish();
    drain("wrap_prep_drain");
    chk("wrap_prep_rptr", rptr, 5'b01000);
    chk("wrap_prep_rempty", rempty, 1);
    dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    publish();
    step();
    @(negedge rclk);
    chk("wrap_rcount_full", rcount, 16);
    chk("wrap_ae_full", ralmost_empty, 0);
    chk("wrap_ren", mem_ren, 1);
    chk("wrap_raddr15", raddr, 15);
    chk("wrap_rptr_pre", rptr, 5'b01000);
    step();
    @(negedge rclk);
    chk("wrap_rptr_msb", rptr, 5'b11000);
    chk("wrap_raddr0", raddr, 0);
    chk("wrap_rcount15", rcount, 15);
    step();
    dout_ready = 1'b1;
    drain("wrap_drain");
    chk("wrap_end_rcount", rcount, 0);
    chk("wrap_end_rempty", rempty, 1);
    chk("wrap_end_rptr", rptr, 5'b10000);

    // Mid-burst reset
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'hC0 + i));
    publish();
    step();
    step();
    step();
    @(negedge rclk);
    chk("mid_busy_valid", dout_valid, 1);
    chk("mid_busy_ren", mem_ren, 1);
    #2;
    rrst = 1'b1;
    wptr_sync = 5'd0;
    wbin = 0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_rempty", rempty, 1);
    chk("mid_rst_rptr", rptr, 0);
    chk("mid_rst_rcount", rcount, 0);
    chk("mid_rst_ae", ralmost_empty, 1);
    chk("mid_rst_ren", mem_ren, 0);
    step();
    step();
    rrst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge rclk);
      chk($sformatf("post_rst_valid_%0d", k), dout_valid, 0);
      chk($sformatf("post_rst_ren_%0d", k), mem_ren, 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
